// File: rtl/rsa_pkg.sv
// Shared constants, FSM state encoding and exponent-bit helpers for the RSA exponentiation sequencer.
// Optional trailing-zero skip is enabled with the RSA_EARLY_EXIT_EN macro.
package rsa_pkg;
  localparam int BITS  = 256;
  localparam int MP_W  = 270;
  localparam int IDX_W = $clog2(BITS) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BITS - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_PREP  = 4'd1,
    S_PWAIT = 4'd2,
    S_MUL   = 4'd3,
    S_MWAIT = 4'd4,
    S_SQR   = 4'd5,
    S_SWAIT = 4'd6,
    S_NEXT  = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  function automatic logic bit_set(input logic [BITS-1:0] v, input logic [IDX_W-1:0] pos);
    return |(v & ({{(BITS-1){1'b0}}, 1'b1} << pos));
  endfunction

  // True when no exponent bit at or above pos remains
  function automatic logic upper_zero(input logic [BITS-1:0] v, input logic [IDX_W-1:0] pos);
    return (v >> pos) == {BITS{1'b0}};
  endfunction
endpackage

// File: rtl/rsa_core_ctrl_if.sv
// Host and arithmetic-engine signals of the RSA sequencer; slave is the sequencer side.
interface rsa_core_ctrl_if;
  import rsa_pkg::*;

  logic            i_start;
  logic [BITS-1:0] i_a;
  logic [BITS-1:0] i_d;
  logic [BITS-1:0] i_n;
  logic [BITS-1:0] o_a_pow_d;
  logic            o_finished;
  logic            o_busy;
  logic            o_mp_start;
  logic [MP_W-1:0] o_mp_a;
  logic            i_mp_end;
  logic [MP_W-1:0] i_mp_a;
  logic            o_mt_start;
  logic [BITS-1:0] o_mt_a;
  logic [BITS-1:0] o_mt_b;
  logic            i_mt_end;
  logic [BITS-1:0] i_mt_a;

  modport slave (
    input  i_start, i_a, i_d, i_n, i_mp_end, i_mp_a, i_mt_end, i_mt_a,
    output o_a_pow_d, o_finished, o_busy, o_mp_start, o_mp_a, o_mt_start, o_mt_a, o_mt_b
  );

  modport master (
    output i_start, i_a, i_d, i_n, i_mp_end, i_mp_a, i_mt_end, i_mt_a,
    input  o_a_pow_d, o_finished, o_busy, o_mp_start, o_mp_a, o_mt_start, o_mt_a, o_mt_b
  );
endinterface

// File: rtl/rsa_core_ctrl.sv
// LSB-first square-and-multiply sequencer driving one ModProd pre-scaler and one shared Montgomery multiplier.
// RSA_EARLY_EXIT_EN skips the squarings left once no higher exponent bits remain.
module rsa_core_ctrl
  import rsa_pkg::*;
(
  input logic         i_clk,
  input logic         i_rst_n,
  rsa_core_ctrl_if.slave bus
);
  state_t           state_r, state_s;
  logic [BITS-1:0]  d_r, d_s;
  logic [BITS-1:0]  m_r, m_s;
  logic [BITS-1:0]  t_r, t_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [IDX_W-1:0] idx_inc_s;
  logic [BITS-1:0]  a_pow_d_r, a_pow_d_s;
  logic             finished_r, finished_s;
  logic             busy_r, busy_s;
  logic             mp_start_r, mp_start_s;
  logic [MP_W-1:0]  mp_a_r, mp_a_s;
  logic             mt_start_r, mt_start_s;
  logic [BITS-1:0]  mt_a_r, mt_a_s;
  logic [BITS-1:0]  mt_b_r, mt_b_s;

  assign bus.o_a_pow_d  = a_pow_d_r;
  assign bus.o_finished = finished_r;
  assign bus.o_busy     = busy_r;
  assign bus.o_mp_start = mp_start_r;
  assign bus.o_mp_a     = mp_a_r;
  assign bus.o_mt_start = mt_start_r;
  assign bus.o_mt_a     = mt_a_r;
  assign bus.o_mt_b     = mt_b_r;

  // Next-state and next-output logic; m stays in the plain domain, t in the Montgomery domain
  always_comb begin
    state_s    = state_r;
    d_s        = d_r;
    m_s        = m_r;
    t_s        = t_r;
    idx_s      = idx_r;
    a_pow_d_s  = a_pow_d_r;
    finished_s = 1'b0;
    busy_s     = busy_r;
    mp_start_s = 1'b0;
    mp_a_s     = mp_a_r;
    mt_start_s = 1'b0;
    mt_a_s     = mt_a_r;
    mt_b_s     = mt_b_r;
    idx_inc_s  = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};

    case (state_r)
      S_IDLE: begin
        if (bus.i_start) begin
          state_s   = S_PREP;
          d_s       = bus.i_d;
          mp_a_s    = {{(MP_W-BITS){1'b0}}, bus.i_a};
          m_s       = {{(BITS-1){1'b0}}, 1'b1};
          idx_s     = {IDX_W{1'b0}};
          busy_s    = 1'b1;
          a_pow_d_s = {BITS{1'b0}};
        end else begin
          state_s = S_IDLE;
        end
      end
      S_PREP: begin
        mp_start_s = 1'b1;
        state_s    = S_PWAIT;
      end
      S_PWAIT: begin
        if (bus.i_mp_end) begin
          t_s     = bus.i_mp_a[BITS-1:0];
          state_s = d_r[0] ? S_MUL : S_SQR;
        end else begin
          state_s = S_PWAIT;
        end
      end
      S_MUL: begin
        mt_start_s = 1'b1;
        mt_a_s     = m_r;
        mt_b_s     = t_r;
        state_s    = S_MWAIT;
      end
      S_MWAIT: begin
        if (bus.i_mt_end) begin
          m_s = bus.i_mt_a;
`ifdef RSA_EARLY_EXIT_EN
          state_s = upper_zero(d_r, idx_inc_s) ? S_DONE : S_SQR;
`else
          state_s = S_SQR;
`endif
        end else begin
          state_s = S_MWAIT;
        end
      end
      S_SQR: begin
        mt_start_s = 1'b1;
        mt_a_s     = t_r;
        mt_b_s     = t_r;
        state_s    = S_SWAIT;
      end
      S_SWAIT: begin
        if (bus.i_mt_end) begin
          t_s     = bus.i_mt_a;
          state_s = S_NEXT;
        end else begin
          state_s = S_SWAIT;
        end
      end
      S_NEXT: begin
        if (idx_r == IDX_LAST) begin
          state_s = S_DONE;
`ifdef RSA_EARLY_EXIT_EN
        end else if (upper_zero(d_r, idx_inc_s)) begin
          state_s = S_DONE;
`endif
        end else begin
          idx_s   = idx_inc_s;
          state_s = bit_set(d_r, idx_inc_s) ? S_MUL : S_SQR;
        end
      end
      S_DONE: begin
        a_pow_d_s  = m_r;
        finished_s = 1'b1;
        busy_s     = 1'b0;
        state_s    = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, working and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= S_IDLE;
      d_r        <= {BITS{1'b0}};
      m_r        <= {{(BITS-1){1'b0}}, 1'b1};
      t_r        <= {BITS{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      a_pow_d_r  <= {BITS{1'b0}};
      finished_r <= 1'b0;
      busy_r     <= 1'b0;
      mp_start_r <= 1'b0;
      mp_a_r     <= {MP_W{1'b0}};
      mt_start_r <= 1'b0;
      mt_a_r     <= {BITS{1'b0}};
      mt_b_r     <= {BITS{1'b0}};
    end else begin
      state_r    <= state_s;
      d_r        <= d_s;
      m_r        <= m_s;
      t_r        <= t_s;
      idx_r      <= idx_s;
      a_pow_d_r  <= a_pow_d_s;
      finished_r <= finished_s;
      busy_r     <= busy_s;
      mp_start_r <= mp_start_s;
      mp_a_r     <= mp_a_s;
      mt_start_r <= mt_start_s;
      mt_a_r     <= mt_a_s;
      mt_b_r     <= mt_b_s;
    end
  end
endmodule
